// File: rtl/bram_stream_reader_if.sv
// Stream interface carrying words out of the BRAM read sequencer.
// Latency: none (wires only).
// Backpressure: out_ready from the slave; the master holds out_data/out_valid while stalled.
// Signals: out_data (RAM_WIDTH), out_valid, out_ready, and out_last when
// BRAM_STREAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH = 8
);
  logic [RAM_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic                 out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
`else
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM reader: turns a (start_address, length) command into a valid/ready word stream.
// Latency: first out_valid two clock edges after the edge that accepts start; then 1 word/cycle.
// Backpressure: 3-entry skid FIFO; reads are issued only when FIFO + in-flight < 3, so out_ready
// never reaches the RAM controls combinationally.
//
// Ports: clock, reset_n (synchronous, active low); command: start, start_address, length,
// busy, done; RAM side: ram_enable, write_enable (tied 0), address, ram_data (1-cycle latency);
// stream: bram_stream_reader_if.master (out_data, out_valid, out_ready[, out_last]).
// Optional macro BRAM_STREAM_READER_LAST_EN adds out_last, high with the final word of a command.
module bram_stream_reader #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] start_address,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  bram_stream_reader_if.master     stream
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   LEN_ONE  = 1;
  localparam logic [RAM_ADDR_BITS:0]   LEN_ZERO = 0;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q;
  logic [RAM_ADDR_BITS:0]   remaining_q;
  logic                     in_flight_q;
  logic [1:0]               count_q;
  logic [1:0]               wr_q;
  logic [1:0]               rd_q;
  logic [RAM_WIDTH-1:0]     buf_data_q [3];
  logic                     done_q;

  logic       issue;
  logic       accept;
  logic       accept_empty;
  logic       drain_done;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  function automatic logic [1:0] bump(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Next state and read-issue decision, from registered state only.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    accept       = 1'b0;
    accept_empty = 1'b0;
    drain_done   = 1'b0;
    // Words already buffered plus the one the RAM is producing must leave room.
    occupancy    = {1'b0, count_q} + {2'b00, in_flight_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != LEN_ZERO) begin
            accept  = 1'b1;
            state_d = READ;
          end else begin
            accept_empty = 1'b1;
          end
        end
      end
      READ: begin
        if (remaining_q != LEN_ZERO && occupancy < 3'd3) begin
          issue = 1'b1;
          if (remaining_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_flight_q && count_q == 2'd0) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM answers one cycle after an issue; that is the push cycle.
  assign push = in_flight_q;
  assign pop  = stream.out_valid & stream.out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      count_q     <= 2'd0;
      wr_q        <= 2'd0;
      rd_q        <= 2'd0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) buf_data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= accept_empty | drain_done;
      in_flight_q <= issue;
      if (accept) begin
        ptr_q       <= start_address;
        remaining_q <= length;
      end else if (issue) begin
        ptr_q       <= ptr_q + ADDR_ONE;   // wraps naturally at 2**RAM_ADDR_BITS
        remaining_q <= remaining_q - LEN_ONE;
      end
      if (push) begin
        buf_data_q[wr_q] <= ram_data;
        wr_q             <= bump(wr_q);
      end
      if (pop) rd_q <= bump(rd_q);
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (!push && pop) count_q <= count_q - 2'd1;
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  // Tag travels with the read so the final word is marked when it leaves the FIFO.
  logic       in_flight_last_q;
  logic [2:0] buf_last_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_flight_last_q <= 1'b0;
      buf_last_q       <= 3'b000;
    end else begin
      in_flight_last_q <= issue && (remaining_q == LEN_ONE);
      if (push) buf_last_q[wr_q] <= in_flight_last_q;
    end
  end

  assign stream.out_last = stream.out_valid & buf_last_q[rd_q];
`endif

  assign stream.out_valid = (count_q != 2'd0);
  assign stream.out_data  = buf_data_q[rd_q];
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign ram_enable       = issue;
  assign write_enable     = 1'b0;
  assign address          = ptr_q;

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read sequencer placed directly in front of the single-port block RAM's read side. On a start command it issues sequential reads from a start address for a given length, absorbs the RAM's fixed 1-cycle read latency, and presents the words as a valid/ready stream. Backpressure is buffered so that `out_ready` never combinationally reaches the RAM controls. Sustained throughput is 1 word/cycle.

Parameters:
- RAM_WIDTH, 8, data word width; must match the RAM.
- RAM_ADDR_BITS, 10, RAM address width; must match the RAM.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- start_address  in  RAM_ADDR_BITS  first word address, sampled on accepted start.
- length  in  RAM_ADDR_BITS+1  word count 0..2**RAM_ADDR_BITS, sampled on accepted start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- ram_enable  out  1  to RAM enable; high exactly on read-issue cycles.
- write_enable  out  1  to RAM write enable; constant 0.
- address  out  RAM_ADDR_BITS  to RAM address.
- ram_data  in  RAM_WIDTH  from RAM output_data; valid 1 cycle after a ram_enable cycle.
- out_data  out  RAM_WIDTH  stream data (head of buffer).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.

Behaviour:
- Reset (reset_n=0 at clock edge): FSM=IDLE; busy=0, done=0, ram_enable=0, address=0, out_valid=0, out_data=0.
  - Buffer count, in-flight flag and remaining count all cleared.
  - A read in flight at reset is discarded: its data is not captured.
- FSM states IDLE, READ, DRAIN.
  - IDLE, start=1, length>0: latch start_address and length, go to READ.
  - IDLE, start=1, length=0: stay IDLE; done=1 on the next cycle; no RAM access.
  - start in READ or DRAIN: ignored.
  - READ: issue reads. When the last read has been issued, go to DRAIN.
  - DRAIN: wait until in-flight=0 and buffer empty, then go to IDLE with done=1 that cycle (registered pulse; busy=0 in the same cycle).
- Buffer: 3-entry FIFO. Read issue condition: state=READ, remaining>0, and (buffer count + in-flight) < 3.
  - The condition uses registered state only; no out_ready term.
  - Issue cycle: ram_enable=1 and address=current pointer. The pointer increments modulo 2**RAM_ADDR_BITS, wrapping from max to 0. remaining decrements.
  - Cycle after issue: ram_data is pushed into the FIFO.
- Read latency: first out_valid appears 2 cycles after the start edge (start accepted at edge N, first issue in cycle N+1, out_valid in cycle N+2).
- Stream rules:
  - out_valid = (count != 0).
  - A handshake (out_valid & out_ready) pops one word.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - Simultaneous push and pop in one cycle: count is unchanged and order is preserved.
- Full-length command (length=2**RAM_ADDR_BITS): reads every address exactly once, wrapping through 0 when start_address≠0.
- write_enable is always 0. The block never writes the RAM.

Optional Feature:
- Macro BRAM_STREAM_READER_LAST_EN.
- Defined: adds output port `out_last` (1 bit).
  - out_last=1 alongside out_valid on the final word of a command, else 0.
  - Held stable under backpressure together with out_data.
  - Reset value 0.
  - A length-0 command produces no out_last.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- RAM preloaded with addr i -> data i; start_address=5, length=4, out_ready=1:
  - ram_enable high on 4 consecutive cycles with address 5..8.
  - out_data 5,6,7,8 on 4 consecutive cycles, first out_valid 2 cycles after start.
  - done pulses once, then busy=0.
- Same command with out_ready held 0 for 10 cycles:
  - Exactly 3 reads issued, then ram_enable stays 0; out_data=5 stable.
  - On release, 5,6,7,8 delivered in order with none lost or duplicated.
- RAM_ADDR_BITS=10, start_address=1022, length=4:
  - Addresses 1022, 1023, 0, 1 are read; data out in that order.
- length=0: no ram_enable pulse, out_valid stays 0, done=1 one cycle after start, busy stays 0.
- reset_n=0 one cycle after the second read issue of a length=8 command:
  - All outputs go to reset values; no further out_valid.
  - A new command with start_address=20, length=2 yields exactly 20,21.
- start pulsed during READ with different start_address/length: ignored; the original command completes unchanged. With BRAM_STREAM_READER_LAST_EN defined, out_last=1 only on its final word.
